// File: rtl/mem_stage.sv
// MEM stage of the five-stage pipeline: data-memory req/ack transfer, front-end stall and MEM/WB register.
// Optional watchdog on the memory transfer is enabled with `define MEM_TIMEOUT_EN.
module mem_stage
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
)
`endif
(
    input  logic        clk,
    input  logic        pc_rst,
    input  logic [31:0] m_aluResult,
    input  logic [31:0] m_writeData,
    input  logic [4:0]  m_writeReg,
    input  logic [2:0]  m_M,
    input  logic [1:0]  m_WB,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] w_readData,
    output logic [31:0] w_aluResult,
    output logic [4:0]  w_writeReg,
    output logic [1:0]  w_WB,
    output logic        mem_err
);
    // state | meaning
    // IDLE  | no transfer outstanding; ALU ops pass, memory ops issue
    // WAIT  | request outstanding, waiting for dmem_ack
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0] state, state_nxt;
    logic       memop, is_load, expire, load_wb;
    logic       unused_branch;

    assign memop         = m_M[1] | m_M[0];
    assign is_load       = m_M[1] & ~m_M[0];
    assign unused_branch = m_M[2];

    assign dmem_we    = m_M[0];
    assign dmem_addr  = {m_aluResult[31:2], 2'b00};
    assign dmem_wdata = m_writeData;

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt;
    logic            mem_err_q;

    // Expiry lands on the TIMEOUT-th WAIT cycle; an ack in that cycle still completes normally.
    assign expire  = (state == WAIT) && !dmem_ack && (wd_cnt == TO_W'(TIMEOUT - 1));
    assign mem_err = mem_err_q;

    always_ff @(posedge clk or negedge pc_rst) begin
        if (!pc_rst) begin
            wd_cnt    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (state == IDLE && memop)
                wd_cnt <= '0;
            else if (state == WAIT && !dmem_ack)
                wd_cnt <= wd_cnt + 1'b1;
            if (expire)
                mem_err_q <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        load_wb   = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    load_wb = 1'b1;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    load_wb   = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    state_nxt = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset abandons any transfer at once, not at the next edge.
        if (!pc_rst) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge pc_rst) begin
        if (!pc_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge pc_rst) begin
        if (!pc_rst) begin
            w_readData  <= '0;
            w_aluResult <= '0;
            w_writeReg  <= '0;
            w_WB        <= '0;
        end else if (load_wb) begin
            w_readData  <= is_load ? dmem_rdata : 32'd0;
            w_aluResult <= m_aluResult;
            w_writeReg  <= m_writeReg;
            w_WB        <= m_WB;
        end else begin
            w_readData  <= '0;
            w_aluResult <= '0;
            w_writeReg  <= '0;
            w_WB        <= '0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and randomized instruction streams against a transaction-level model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        pc_rst;
    logic [31:0] m_aluResult, m_writeData, dmem_rdata;
    logic [4:0]  m_writeReg;
    logic [2:0]  m_M;
    logic [1:0]  m_WB;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, mem_stall, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, w_readData, w_aluResult;
    logic [4:0]  w_writeReg;
    logic [1:0]  w_WB;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    mem_stage #(.TIMEOUT(4), .TO_W(8)) dut (
`else
    mem_stage dut (
`endif
        .clk(clk), .pc_rst(pc_rst),
        .m_aluResult(m_aluResult), .m_writeData(m_writeData), .m_writeReg(m_writeReg),
        .m_M(m_M), .m_WB(m_WB),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
        .w_readData(w_readData), .w_aluResult(w_aluResult), .w_writeReg(w_writeReg),
        .w_WB(w_WB), .mem_err(mem_err)
    );

    // Runs one instruction from IDLE: memory ops see their ack after n WAIT cycles.
    // Starts and ends 1 time unit after a rising edge.
    task automatic run_instr(input logic [2:0] mm, input logic [1:0] wb, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [4:0] wr, input int n,
                             input logic [31:0] rd, input bit noise);
        bit          memop;
        int          cycles;
        int          stalls;
        logic [31:0] exp_rd;
        memop  = (mm[1:0] != 2'b00);
        cycles = memop ? n + 1 : 1;
        stalls = 0;
        exp_rd = (mm[1:0] == 2'b10) ? rd : 32'd0;
        for (int c = 0; c < cycles; c++) begin
            m_M = mm; m_WB = wb; m_aluResult = alu; m_writeData = wd; m_writeReg = wr;
            dmem_ack   = memop && (c == n);
            if (c == 0 && noise) dmem_ack = 1'($urandom_range(0, 1));
            dmem_rdata = (memop && c == n) ? rd : $urandom;
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (memop && c != n)) begin
                n_fail++;
                $display("FAIL stall cyc%0d mm=%b: got %b want %b", c, mm, mem_stall, memop && c != n);
            end
            n_checks++;
            if (dmem_req !== memop) begin
                n_fail++;
                $display("FAIL req cyc%0d mm=%b: got %b want %b", c, mm, dmem_req, memop);
            end
            if (memop) begin
                n_checks++;
                if (dmem_addr !== {alu[31:2], 2'b00} || dmem_we !== mm[0] || dmem_wdata !== wd) begin
                    n_fail++;
                    $display("FAIL memif addr=%h we=%b wdata=%h want %h %b %h",
                             dmem_addr, dmem_we, dmem_wdata, {alu[31:2], 2'b00}, mm[0], wd);
                end
            end
            if (mem_stall === 1'b1) stalls++;
            @(posedge clk); #1;
            if (c != cycles - 1) begin
                n_checks++;
                if (w_WB !== 2'b00 || w_aluResult !== 32'd0) begin
                    n_fail++;
                    $display("FAIL bubble cyc%0d: w_WB=%b w_alu=%h want 0", c, w_WB, w_aluResult);
                end
            end
        end
        n_checks++;
        if (stalls != (memop ? n : 0)) begin
            n_fail++;
            $display("FAIL stall_count mm=%b: got %0d want %0d", mm, stalls, memop ? n : 0);
        end
        n_checks++;
        if (w_readData !== exp_rd || w_aluResult !== alu || w_writeReg !== wr || w_WB !== wb) begin
            n_fail++;
            $display("FAIL memwb mm=%b: got rd=%h alu=%h wr=%0d wb=%b want rd=%h alu=%h wr=%0d wb=%b",
                     mm, w_readData, w_aluResult, w_writeReg, w_WB, exp_rd, alu, wr, wb);
        end
    endtask

    task automatic test_reset;
        pc_rst = 1'b0;
        m_M = 3'b010; m_WB = 2'b11; m_aluResult = 32'h40; m_writeData = 0; m_writeReg = 3;
        dmem_ack = 1'b0; dmem_rdata = 0;
        #12;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || w_WB !== 2'b00 || w_readData !== 32'd0 ||
            w_aluResult !== 32'd0 || w_writeReg !== 5'd0 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b stall=%b wb=%b rd=%h alu=%h wr=%0d err=%b want all 0",
                     dmem_req, mem_stall, w_WB, w_readData, w_aluResult, w_writeReg, mem_err);
        end
        m_M = 3'b000;
        pc_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        run_instr(3'b000, 2'b10, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_transfer;
        test_alu();
        m_M = 3'b010; m_aluResult = 32'h200; dmem_ack = 1'b0;
        #2;
        n_checks++;
        if (dmem_req !== 1'b1 || w_aluResult !== 32'h1234) begin
            n_fail++;
            $display("FAIL pre_reset: req=%b alu=%h want 1 00001234", dmem_req, w_aluResult);
        end
        pc_rst = 1'b0; #1;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || w_WB !== 2'b00 || w_aluResult !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle: req=%b stall=%b wb=%b alu=%h want 0", dmem_req, mem_stall, w_WB, w_aluResult);
        end
        pc_rst = 1'b1;
        @(posedge clk); #1;
        #2 pc_rst = 1'b0; #1;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || w_WB !== 2'b00 || w_aluResult !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wait: req=%b stall=%b wb=%b alu=%h want 0", dmem_req, mem_stall, w_WB, w_aluResult);
        end
        m_M = 3'b000; m_WB = 2'b10; m_aluResult = 32'h77;
        pc_rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: req=%b stall=%b want 0 0", dmem_req, mem_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        run_instr(3'b010, 2'b11, 32'h103, 32'h0, 5'd9, 3, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_store;
        run_instr(3'b001, 2'b00, 32'h80, 32'hCAFE0001, 5'd0, 1, 32'h5555AAAA, 1'b0);
        run_instr(3'b011, 2'b01, 32'h84, 32'h12345678, 5'd2, 2, 32'hFFFF0000, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_instr(3'b010, 2'b11, 32'h1000, 32'h0, 5'd7, 1, 32'h0BADF00D, 1'b0);
        run_instr(3'b001, 2'b00, 32'h1004, 32'h600DCAFE, 5'd0, 1, 32'h0, 1'b0);
        run_instr(3'b010, 2'b11, 32'h1008, 32'h0, 5'd8, 1, 32'h13579BDF, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(1, 3)), $urandom, $urandom,
                      5'($urandom_range(0, 31)), $urandom_range(1, 4), $urandom, 1'b1);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        m_M = 3'b010; m_WB = 2'b11; m_aluResult = 32'h300; m_writeReg = 4; dmem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (c < 4)) begin
                n_fail++;
                $display("FAIL timeout_stall cyc%0d: got %b want %b", c, mem_stall, c < 4);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (mem_err !== 1'b1 || w_WB !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_flag: err=%b wb=%b want 1 00", mem_err, w_WB);
        end
        run_instr(3'b000, 2'b10, 32'h55, 32'h0, 5'd1, 0, 32'h0, 1'b0);
        run_instr(3'b001, 2'b00, 32'h58, 32'h1, 5'd0, 2, 32'h0, 1'b0);
        n_checks++;
        if (mem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b want 1", mem_err);
        end
        pc_rst = 1'b0; #1;
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b want 0", mem_err);
        end
        m_M = 3'b000; pc_rst = 1'b1;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_timeout;
        run_instr(3'b010, 2'b11, 32'h300, 32'h0, 5'd4, 20, 32'hA5A5A5A5, 1'b0);
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_err: err=%b want 0", mem_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_reset_mid_transfer();
        test_load();
        test_store();
        test_back_to_back();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
